// File: rtl/cam_pkg.sv
// Shared state encoding and default timing for the OV7670 power sequencer.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWDN_WAIT = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CONFIG    = 3'd4,
        ST_READY     = 3'd5,
        ST_FAULT     = 3'd6
    } cam_state_e;

    localparam int unsigned CAM_CLK_HZ   = 50_000_000;
    localparam int unsigned CAM_TICK_HZ  = 1000;
    localparam int unsigned CAM_T_PWDN   = 10;
    localparam int unsigned CAM_T_RST    = 5;
    localparam int unsigned CAM_T_SETTLE = 300;
    localparam int unsigned CAM_T_CFG_TO = 1000;

    // A zero-length delay still has to last one tick.
    function automatic int unsigned t_eff(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 and flags the terminal count as a tick.
module cam_tick_gen #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Tick depends on the registered count only, so clr may be derived from it.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cam_pwr_seq.sv
// OV7670 power-up/down sequencer: XCLK gate, PWDN, RESET, then SCCB hand-off.
// Define CAM_PWR_SEQ_TIMEOUT_EN to fault on a configuration that never completes.
module cam_pwr_seq
    import cam_pkg::*;
#(
    parameter int unsigned CLK_HZ   = CAM_CLK_HZ,
    parameter int unsigned TICK_HZ  = CAM_TICK_HZ,
    parameter int unsigned T_PWDN   = CAM_T_PWDN,
    parameter int unsigned T_RST    = CAM_T_RST,
    parameter int unsigned T_SETTLE = CAM_T_SETTLE,
    parameter int unsigned T_CFG_TO = CAM_T_CFG_TO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cfg_done,
    output logic       xclk_en,
    output logic       cam_pwdn,
    output logic       cam_reset_n,
    output logic       cfg_start,
    output logic       ready,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned TCNT_MAX = max2(max2(t_eff(T_PWDN), t_eff(T_RST)),
                                            max2(t_eff(T_SETTLE), t_eff(T_CFG_TO)));
    localparam int unsigned TCNT_W = (TCNT_MAX > 1) ? $clog2(TCNT_MAX) : 1;

    // The counter holds completed ticks, so the last tick of a state is seen at T-1.
    localparam logic [TCNT_W-1:0] PWDN_LAST   = TCNT_W'(t_eff(T_PWDN) - 1);
    localparam logic [TCNT_W-1:0] RST_LAST    = TCNT_W'(t_eff(T_RST) - 1);
    localparam logic [TCNT_W-1:0] SETTLE_LAST = TCNT_W'(t_eff(T_SETTLE) - 1);
`ifdef CAM_PWR_SEQ_TIMEOUT_EN
    localparam logic [TCNT_W-1:0] CFG_LAST    = TCNT_W'(t_eff(T_CFG_TO) - 1);
`endif

    cam_state_e        state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              xclk_en_q, xclk_en_d;
    logic              cam_pwdn_q, cam_pwdn_d;
    logic              cam_reset_n_q, cam_reset_n_d;
    logic              cfg_start_q, cfg_start_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              tick;
    logic              timed;
    logic              state_chg;
    logic              pre_clr;

    cam_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        timed = 1'b0;
        case (state_q)
            ST_PWDN_WAIT, ST_RST_HOLD, ST_SETTLE: timed = 1'b1;
`ifdef CAM_PWR_SEQ_TIMEOUT_EN
            ST_CONFIG:                            timed = 1'b1;
`endif
            default:                              timed = 1'b0;
        endcase
    end

    // Next state; stop overrides everything and start only matters in OFF.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:       if (start) state_d = ST_PWDN_WAIT;
            ST_PWDN_WAIT: if (tick && tcnt_q == PWDN_LAST) state_d = ST_RST_HOLD;
            ST_RST_HOLD:  if (tick && tcnt_q == RST_LAST) state_d = ST_SETTLE;
            ST_SETTLE:    if (tick && tcnt_q == SETTLE_LAST) state_d = ST_CONFIG;
            ST_CONFIG: begin
                if (cfg_done) state_d = ST_READY;
`ifdef CAM_PWR_SEQ_TIMEOUT_EN
                else if (tick && tcnt_q == CFG_LAST) state_d = ST_FAULT;
`endif
            end
            ST_READY:     state_d = ST_READY;
`ifdef CAM_PWR_SEQ_TIMEOUT_EN
            ST_FAULT:     state_d = ST_FAULT;
`endif
            default:      state_d = ST_OFF;
        endcase
        if (stop) state_d = ST_OFF;
    end

    // Prescaler and tick counter restart on every state change so each
    // timed state lasts exactly T*DIV cycles; both idle in untimed states.
    always_comb begin
        state_chg = (state_d != state_q);
        pre_clr   = state_chg || !timed;
        tcnt_d    = tcnt_q;
        if (timed && tick) tcnt_d = tcnt_q + TCNT_W'(1);
        if (state_chg)     tcnt_d = '0;
    end

    // Outputs decode the next state so they switch on the same edge as state_q.
    always_comb begin
        xclk_en_d     = 1'b1;
        cam_pwdn_d    = 1'b0;
        cam_reset_n_d = 1'b1;
        cfg_start_d   = 1'b0;
        ready_d       = 1'b0;
        busy_d        = 1'b0;
        fault_d       = 1'b0;
        case (state_d)
            ST_OFF: begin
                xclk_en_d     = 1'b0;
                cam_pwdn_d    = 1'b1;
                cam_reset_n_d = 1'b0;
            end
            ST_PWDN_WAIT: begin
                cam_pwdn_d    = 1'b1;
                cam_reset_n_d = 1'b0;
                busy_d        = 1'b1;
            end
            ST_RST_HOLD: begin
                cam_reset_n_d = 1'b0;
                busy_d        = 1'b1;
            end
            ST_SETTLE: busy_d = 1'b1;
            ST_CONFIG: begin
                busy_d      = 1'b1;
                cfg_start_d = (state_q != ST_CONFIG);
            end
            ST_READY: ready_d = 1'b1;
`ifdef CAM_PWR_SEQ_TIMEOUT_EN
            ST_FAULT: fault_d = 1'b1;
`endif
            default: begin
                xclk_en_d     = 1'b0;
                cam_pwdn_d    = 1'b1;
                cam_reset_n_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            tcnt_q        <= '0;
            xclk_en_q     <= 1'b0;
            cam_pwdn_q    <= 1'b1;
            cam_reset_n_q <= 1'b0;
            cfg_start_q   <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            xclk_en_q     <= xclk_en_d;
            cam_pwdn_q    <= cam_pwdn_d;
            cam_reset_n_q <= cam_reset_n_d;
            cfg_start_q   <= cfg_start_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    assign xclk_en     = xclk_en_q;
    assign cam_pwdn    = cam_pwdn_q;
    assign cam_reset_n = cam_reset_n_q;
    assign cfg_start   = cfg_start_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with DIV=10, T_PWDN=2, T_RST=1, T_SETTLE=3, T_CFG_TO=4.
module tb_cam_pwr_seq;

    logic       clk = 1'b0;
    logic       rst, start, stop, cfg_done;
    logic       xclk_en, cam_pwdn, cam_reset_n, cfg_start, ready, busy, fault;
    logic [2:0] state_o;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    cam_pwr_seq #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .T_PWDN   (2),
        .T_RST    (1),
        .T_SETTLE (3),
        .T_CFG_TO (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_done    (cfg_done),
        .xclk_en     (xclk_en),
        .cam_pwdn    (cam_pwdn),
        .cam_reset_n (cam_reset_n),
        .cfg_start   (cfg_start),
        .ready       (ready),
        .busy        (busy),
        .fault       (fault),
        .state_o     (state_o)
    );

    // {xclk_en, cam_pwdn, cam_reset_n, cfg_start, ready, busy, fault, state}
    function automatic logic [9:0] exp_vec(input int st, input logic cs);
        case (st)
            0:       return {7'b0100000, 3'd0};
            1:       return {7'b1100010, 3'd1};
            2:       return {7'b1000010, 3'd2};
            3:       return {7'b1010010, 3'd3};
            4:       return {3'b101, cs, 3'b010, 3'd4};
            5:       return {7'b1010100, 3'd5};
            default: return {7'b1010001, 3'd6};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = {xclk_en, cam_pwdn, cam_reset_n, cfg_start, ready, busy, fault, state_o};
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Starts from OFF and checks every cycle up to CONFIG entry at cycle 61.
    task automatic run_powerup(input string tag);
        int st;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 61; c++) begin
            if (c <= 20)      st = 1;
            else if (c <= 30) st = 2;
            else if (c <= 60) st = 3;
            else              st = 4;
            if (c == 40) cfg_done = 1'b1;
            if (c == 45) start = 1'b1;
            chk(tag, exp_vec(st, c == 61));
            if (c < 61) begin
                step();
                cfg_done = 1'b0;
                start    = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_done = 1'b0;
        step();
        step();
        chk("reset", exp_vec(0, 1'b0));
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            chk("idle", exp_vec(0, 1'b0));
        end

        // full power-up, then cfg_done 5 cycles after cfg_start
        run_powerup("powerup1");
        for (int c = 62; c <= 66; c++) begin
            step();
            chk("config_wait", exp_vec(4, 1'b0));
        end
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        chk("ready", exp_vec(5, 1'b0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ready_hold", exp_vec(5, 1'b0));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_ready", exp_vec(0, 1'b0));

        // stop together with start while OFF stays OFF
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stop_start_off", exp_vec(0, 1'b0));

        // stop+start during SETTLE
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 35; c++) step();
        chk("settle_reached", exp_vec(3, 1'b0));
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stop_settle", exp_vec(0, 1'b0));
        step();
        chk("stop_settle_hold", exp_vec(0, 1'b0));
        run_powerup("powerup2");
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_config", exp_vec(0, 1'b0));

        // rst during RST_HOLD, then full replay
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 25; c++) step();
        chk("rst_hold_reached", exp_vec(2, 1'b0));
        rst = 1'b1; start = 1'b1; stop = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        chk("rst_mid", exp_vec(0, 1'b0));
        step();
        run_powerup("powerup3");

        // no cfg_done: timeout behaviour
        for (int c = 62; c <= 100; c++) begin
            step();
            chk("cfg_pending", exp_vec(4, 1'b0));
        end
        for (int c = 101; c <= 106; c++) begin
            start = 1'b1;
            step();
            start = 1'b0;
`ifdef CAM_PWR_SEQ_TIMEOUT_EN
            chk("fault", exp_vec(6, 1'b0));
`else
            chk("no_fault", exp_vec(4, 1'b0));
`endif
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_end", exp_vec(0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pwr_seq.md
# cam_pwr_seq

OV7670 power-up/power-down sequencer for the camera capture path. Gates the camera XCLK enable, drives PWDN and RESET with millisecond-accurate delays from an internal prescaler, then hands off to the SCCB register-configuration block and reports when the camera is ready to stream. Sits between the top-level control logic and the clock-divider/SCCB blocks.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- TICK_HZ, 1000, prescaler tick rate; DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2
- T_PWDN, 10, ticks between XCLK enable and PWDN release
- T_RST, 5, ticks RESET is held low
- T_SETTLE, 300, ticks after RESET release before configuration
- T_CFG_TO, 1000, configuration timeout in ticks (used only with the timeout macro)
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  power-up request, level-sampled
- stop  in  1  power-down request, level-sampled
- cfg_done  in  1  one-cycle pulse from the SCCB block when the register load has finished
- xclk_en  out  1  enable for the camera XCLK divider
- cam_pwdn  out  1  camera PWDN pin, 1 = powered down
- cam_reset_n  out  1  camera RESET pin, active low
- cfg_start  out  1  one-cycle pulse starting the SCCB register load
- ready  out  1  camera configured and streaming
- busy  out  1  sequence in progress (any state except OFF, READY, FAULT)
- fault  out  1  configuration timeout latched
- state_o  out  3  current state encoding, for debug

## Operation
- Reset values: state OFF, xclk_en=0, cam_pwdn=1, cam_reset_n=0, cfg_start=0, ready=0, busy=0, fault=0, prescaler=0, tick counter=0.
- States and outputs (xclk_en / cam_pwdn / cam_reset_n):
  - OFF: 0/1/0.
  - PWDN_WAIT: 1/1/0.
  - RST_HOLD: 1/0/0.
  - SETTLE: 1/0/1.
  - CONFIG: 1/0/1.
  - READY: 1/0/1, ready=1.
  - FAULT: 1/0/1, fault=1.
- Transitions:
  - OFF → PWDN_WAIT on start=1.
  - PWDN_WAIT → RST_HOLD after T_PWDN ticks.
  - RST_HOLD → SETTLE after T_RST ticks.
  - SETTLE → CONFIG after T_SETTLE ticks.
  - CONFIG → READY on cfg_done=1.
  - Any state except OFF → OFF on stop=1.
- Prescaler: counts 0..DIV-1, wraps to 0, and produces a tick on terminal count. A tick counter counts ticks within the current timed state.
- Both prescaler and tick counter clear on every state change, so a timed state with parameter T lasts exactly T·DIV cycles. A parameter value of 0 is treated as 1.
- cfg_start pulses high for exactly one cycle: the first cycle in CONFIG.
- Priority: stop > start. start while not in OFF is ignored. cfg_done outside CONFIG is ignored.
- Counter widths: sized by $clog2 of the largest value held. No wrap-around is possible within range.

## Timing
- All outputs are registered and change on the same edge as the state register.
- start sampled at edge k: state=PWDN_WAIT and xclk_en=1 from edge k+1.
- Full power-up (CONFIG entry) after start: (T_PWDN+T_RST+T_SETTLE)·DIV + 1 cycles.
- cfg_done at edge k: ready=1 from edge k+1.
- stop at edge k: OFF reset values from edge k+1, regardless of state.
- rst asserted mid-sequence: reset values at the next edge. rst dominates start and stop.

## Configuration
- CAM_PWR_SEQ_TIMEOUT_EN defined: if CONFIG lasts T_CFG_TO ticks without cfg_done, the block enters FAULT. FAULT is left only by stop or rst.
- Macro undefined: CONFIG waits indefinitely, FAULT is unreachable, and fault is tied 0.

## Structure
- Shared package cam_pkg holds:
  - the state enum: OFF=0, PWDN_WAIT=1, RST_HOLD=2, SETTLE=3, CONFIG=4, READY=5, FAULT=6;
  - default timing constants.
- One sub-module, cam_tick_gen: the prescaler, with a synchronous clear input and a one-cycle tick output.
- The FSM and tick counter stay in cam_pwr_seq.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), T_PWDN=2, T_RST=1, T_SETTLE=3, T_CFG_TO=4.
- Reset then idle: all outputs hold their reset values for 100 cycles; start=0.
- start pulse at cycle 0:
  - xclk_en rises at cycle 1;
  - cam_pwdn falls at cycle 21;
  - cam_reset_n rises at cycle 31;
  - cfg_start pulses at cycle 61 only.
- cfg_done 5 cycles after cfg_start: ready=1 one cycle later; busy=0.
- stop and start asserted together while in SETTLE: OFF values on the next cycle. A later start replays the full timing.
- rst asserted mid-RST_HOLD: reset values on the next edge. The prescaler restarts from 0 on the next start.
- With CAM_PWR_SEQ_TIMEOUT_EN and no cfg_done: fault=1 exactly 40 cycles after CONFIG entry, held until stop.
